// File: rtl/alu_seq.sv
// alu_seq: handshaked sequential ALU with a registered result, sticky ZNCV flags,
// carry-chained ADC/SBC, barrel shifts and an iterative LSB-first shift-add multiplier.
module alu_seq #(
  parameter  int WIDTH = 16,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags
);
  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_NOT = 4'd5;
  localparam logic [3:0] OP_SHL = 4'd6;
  localparam logic [3:0] OP_SHR = 4'd7;
  localparam logic [3:0] OP_SAR = 4'd8;
  localparam logic [3:0] OP_ADC = 4'd9;
  localparam logic [3:0] OP_SBC = 4'd10;
  localparam logic [3:0] OP_MUL = 4'd11;
  localparam logic [3:0] OP_CMP = 4'd12;
  localparam int MSB = WIDTH - 1;
  localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t               state_q;
  logic [WIDTH-1:0]     result_q;
  logic [3:0]           flags_q;
  logic [SHW-1:0]       cnt_q;
  logic [2*WIDTH-1:0]   acc_q;
  logic [2*WIDTH-1:0]   mcand_q;
  logic [WIDTH-1:0]     mplr_q;

  logic                 accept;
  logic [SHW-1:0]       shamt;
  logic                 cin;
  logic [WIDTH:0]       sum_w;
  logic [WIDTH:0]       dif_w;
  logic [WIDTH:0]       shl_w;
  logic [WIDTH:0]       shr_w;
  logic signed [WIDTH:0] sar_w;
  logic [WIDTH-1:0]     zn_d;
  logic [WIDTH-1:0]     res_d;
  logic                 c_d;
  logic                 v_d;
  logic [3:0]           flags_d;
  logic [2*WIDTH-1:0]   prod_d;
  logic [3:0]           mflags_d;

  assign in_ready  = (state_q == IDLE) || (state_q == DONE && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign flags     = flags_q;
  assign shamt     = b[SHW-1:0];
  assign cin       = flags_q[1];

  always_comb begin
    sum_w = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, (op == OP_ADC) & cin};
    dif_w = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, (op == OP_SBC) & cin};
    // Extra bit beyond the shifted word captures the last bit shifted out (carry).
    shl_w = {1'b0, a} << shamt;
    shr_w = {a, 1'b0} >> shamt;
    sar_w = $signed({a, 1'b0}) >>> shamt;
    zn_d  = '0;
    c_d   = 1'b0;
    v_d   = 1'b0;
    case (op)
      OP_ADD, OP_ADC: begin
        zn_d = sum_w[MSB:0];
        c_d  = sum_w[WIDTH];
        v_d  = (a[MSB] == b[MSB]) && (sum_w[MSB] != a[MSB]);
      end
      OP_SUB, OP_SBC, OP_CMP: begin
        zn_d = dif_w[MSB:0];
        c_d  = dif_w[WIDTH];
        v_d  = (a[MSB] != b[MSB]) && (dif_w[MSB] != a[MSB]);
      end
      OP_AND: zn_d = a & b;
      OP_OR:  zn_d = a | b;
      OP_XOR: zn_d = a ^ b;
      OP_NOT: zn_d = ~a;
      OP_SHL: begin
        zn_d = shl_w[MSB:0];
        c_d  = shl_w[WIDTH];
      end
      OP_SHR: begin
        zn_d = shr_w[WIDTH:1];
        c_d  = shr_w[0];
      end
      OP_SAR: begin
        zn_d = sar_w[WIDTH:1];
        c_d  = sar_w[0];
      end
      default: ;
    endcase
    // CMP reports subtraction flags but passes operand A through as the result.
    res_d    = (op == OP_CMP) ? a : zn_d;
    flags_d  = {zn_d == '0, zn_d[MSB], c_d, v_d};
    prod_d   = acc_q + (mplr_q[0] ? mcand_q : '0);
    mflags_d = {prod_d[MSB:0] == '0, prod_d[MSB], |prod_d[2*WIDTH-1:WIDTH], 1'b0};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      result_q <= '0;
      flags_q  <= '0;
      cnt_q    <= '0;
    end else if (accept) begin
      cnt_q <= '0;
      if (op == OP_MUL) begin
        state_q <= BUSY;
      end else begin
        state_q  <= DONE;
        result_q <= res_d;
        flags_q  <= flags_d;
      end
    end else begin
      case (state_q)
        BUSY: begin
          if (cnt_q == CNT_LAST) begin
            state_q  <= DONE;
            result_q <= prod_d[MSB:0];
            flags_q  <= mflags_d;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DONE: if (out_ready) state_q <= IDLE;
        default: ;
      endcase
    end
  end

  // Multiplier datapath: one partial product per BUSY cycle, multiplier consumed LSB-first.
  always_ff @(posedge clk) begin
    if (accept) begin
      acc_q   <= '0;
      mcand_q <= {{WIDTH{1'b0}}, a};
      mplr_q  <= b;
    end else if (state_q == BUSY) begin
      acc_q   <= prod_d;
      mcand_q <= mcand_q << 1;
      mplr_q  <= mplr_q >> 1;
    end
  end

endmodule
